xnor_diff_decoder: RTL and testbench

//  Receive end of the XNOR differential line code used by the encoder logic in this design.

---
 rtl/xnor_diff_decoder.sv | 99 +++++++++
 tb/tb_xnor_diff_decoder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/xnor_diff_decoder.sv
`timescale 1ns / 1ps
// XNOR differential line decoder. Each line sample is XNORed with the previous line level to
// recover the data bit. Recovered bits are packed LSB first into DATA_W-bit words, and each
// word is presented through a single-entry valid/ready holding buffer. If a word completes
// while the buffer is still occupied, that word is dropped and overrun pulses for one cycle.
module xnor_diff_decoder #(
    parameter int unsigned DATA_W   = 8,
    parameter logic        INIT_REF = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_bit,
    input  logic              in_sof,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              overrun
);

    localparam int unsigned      CntW    = $clog2(DATA_W);
    localparam logic [CntW-1:0]  LastIdx = CntW'(DATA_W - 1);

    logic              ref_q, ref_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              overrun_q, overrun_d;

    logic              prev_ref;
    logic              dec;
    logic [CntW-1:0]   idx;
    logic [DATA_W-1:0] word;
    logic              complete;
    logic              accept;
    logic              load;

    // Decode the current sample and work out where it lands in the word being assembled.
    always_comb begin
        // A frame start always decodes against the assumed reference level.
        prev_ref  = in_sof ? INIT_REF : ref_q;
        dec       = ~(in_bit ^ prev_ref);
        idx       = in_sof ? '0 : bit_cnt_q;
        word      = in_sof ? '0 : shift_q;
        word[idx] = dec;
        // in_sof forces idx to 0, so a frame start can never complete a word.
        complete  = in_valid && (idx == LastIdx);
        accept    = out_valid_q && out_ready;
        load      = complete && (!out_valid_q || out_ready);
    end

    // Next-state logic for the deserialiser and the output holding buffer.
    always_comb begin
        ref_d       = ref_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        overrun_d   = complete && !load;

        if (in_valid) begin
            ref_d     = in_bit;
            shift_d   = complete ? '0 : word;
            bit_cnt_d = complete ? '0 : idx + CntW'(1);
        end

        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = word;
        end else if (accept) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; every output is taken straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_q       <= INIT_REF;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            ref_q       <= ref_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_xnor_diff_decoder.sv
`timescale 1ns / 1ps
// Directed bench for xnor_diff_decoder: a line encoder model drives samples, expected words go
// into a queue, and a negedge monitor pops and compares them on every accepted handshake.
module tb_xnor_diff_decoder;

    localparam int unsigned DATA_W   = 8;
    localparam logic        INIT_REF = 1'b1;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              in_valid  = 1'b0;
    logic              in_bit    = 1'b0;
    logic              in_sof    = 1'b0;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic              overrun;
    logic [DATA_W-1:0] out_data;

    int                checks = 0;
    int                errors = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] mon_exp;
    logic              tx_ref     = INIT_REF;
    int                ovr_seen   = 0;
    bit                pulse_mode = 1'b0;
    logic              prev_valid = 1'b0;
    logic              prev_ready = 1'b0;
    logic [DATA_W-1:0] prev_data  = '0;

    always #5 clk = ~clk;

    xnor_diff_decoder #(
        .DATA_W  (DATA_W),
        .INIT_REF(INIT_REF)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_bit   (in_bit),
        .in_sof   (in_sof),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .overrun  (overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: scoreboard pops on handshake, held-data stability, overrun pulse counting.
    always @(negedge clk) begin
        if (rst_n) begin
            if (overrun) ovr_seen++;
            if (out_valid && prev_valid && !prev_ready) check("hold_stable", out_data, prev_data);
            if (pulse_mode && out_valid) check("single_pulse", prev_valid, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", out_data, 32'hFFFF_FFFF);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("word", out_data, mon_exp);
                end
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_data  = out_data;
        end else begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end
    end

    // Present one line sample; returns 1 ns after the edge that sampled it.
    task automatic sample(input logic b, input logic sof);
        in_valid = 1'b1;
        in_bit   = b;
        in_sof   = sof;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_bit   = 1'b0;
    endtask

    // Send raw line levels, bit 0 first.
    task automatic send_line(input logic [7:0] line, input int n, input bit sof);
        for (int i = 0; i < n; i++) begin
            sample(line[i], sof && (i == 0));
            tx_ref = line[i];
        end
    endtask

    // Encode n data bits with the XNOR rule and send them with random idle gaps.
    task automatic send_word(input logic [7:0] d, input int n, input bit sof, input int max_gap);
        logic l;
        if (sof) tx_ref = INIT_REF;
        for (int i = 0; i < n; i++) begin
            l      = ~(d[i] ^ tx_ref);
            tx_ref = l;
            sample(l, sof && (i == 0));
            repeat ($urandom_range(0, max_gap)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Wait (bounded) until every expected word has been accepted and the buffer is empty.
    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(tag, (exp_q.size() == 0) && !out_valid, 1);
    endtask

    initial begin
        int          ov0;
        logic [7:0]  rnd;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: line 1,0,0,1,0,0,1,1 decodes to 0xA5 with one clock latency.
        out_ready = 1'b0;
        exp_q.push_back(8'hA5);
        send_line(8'hC9, 7, 1'b1);
        check("t1_not_before_last", out_valid, 0);
        sample(1'b1, 1'b0);
        check("t1_latency", out_valid, 1);
        check("t1_data", out_data, 8'hA5);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("t1_held_valid", out_valid, 1);
        out_ready = 1'b1;
        drain("t1_drain");

        // 2: all-ones line -> 0xFF; alternating line 0,1,0,1,... -> 0x00, back to back.
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        send_line(8'hFF, 8, 1'b1);
        send_line(8'hAA, 8, 1'b1);
        drain("t2_drain");

        // 3: second word completes while first is held -> dropped, one overrun pulse.
        out_ready = 1'b0;
        ov0 = ovr_seen;
        exp_q.push_back(8'hA5);
        send_word(8'hA5, 8, 1'b1, 0);
        send_word(8'h3C, 8, 1'b1, 0);
        check("t3_overrun_pulse", overrun, 1);
        @(posedge clk);
        #1;
        check("t3_overrun_clear", overrun, 0);
        check("t3_held_data", out_data, 8'hA5);
        check("t3_overrun_count", ovr_seen - ov0, 1);
        out_ready = 1'b1;
        drain("t3_drain");

        // 4: partial word then sof discards silently; also sof on the would-complete sample.
        ov0 = ovr_seen;
        exp_q.push_back(8'hA5);
        send_word(8'h1F, 5, 1'b1, 0);
        send_word(8'hA5, 8, 1'b1, 0);
        drain("t4_drain_a");
        exp_q.push_back(8'hA5);
        send_word(8'h00, 7, 1'b1, 0);
        send_word(8'hA5, 8, 1'b1, 0);
        drain("t4_drain_b");
        check("t4_no_overrun", ovr_seen - ov0, 0);

        // 5: reset with a held word and a partial word in flight.
        out_ready = 1'b0;
        send_word(8'h3C, 8, 1'b1, 0);
        send_word(8'hA5, 4, 1'b1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_valid", out_valid, 0);
        check("t5_async_data", out_data, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("t5_rst_valid", out_valid, 0);
        end
        rst_n     = 1'b1;
        out_ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_word(8'hA5, 8, 1'b1, 0);
        drain("t5_drain");

        // 6: random input gaps, ready held high; each word is a single-cycle pulse.
        pulse_mode = 1'b1;
        exp_q.push_back(8'hA5);
        send_word(8'hA5, 8, 1'b1, 5);
        rnd = 8'($urandom);
        exp_q.push_back(rnd);
        send_word(rnd, 8, 1'b1, 5);
        drain("t6_drain");
        pulse_mode = 1'b0;

        check("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
